// File: rtl/wdt_reset_ctrl.sv
// wdt_reset_ctrl
//   Turns watchdog expiry into a system reset request and escalates to a
//   latched fault when timeouts repeat without a good period in between.
//
//   Each accepted timeout edge normally produces a fixed-length sys_rst
//   pulse. The pulse is followed by a holdoff window in which new edges are
//   ignored. After ESC_LIMIT accepted events with no GOOD_CYC-long quiet
//   stretch in IDLE, the block enters FAULT instead. In FAULT, sys_rst and
//   fault stay high until software pulses fault_clr.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   timeout   : watchdog expiry level from the upstream timer
//   fault_clr : software clear of a latched fault (honoured only in FAULT)
//   sys_rst   : system reset request (registered)
//   fault     : latched escalation fault (registered)
//   to_count  : total accepted timeout events, saturating (registered)
//   state_o   : FSM state, IDLE=0 ASSERT=1 HOLDOFF=2 FAULT=3 (registered)

module wdt_reset_ctrl #(
  parameter int RST_PULSE_CYC = 8,
  parameter int HOLDOFF_CYC   = 16,
  parameter int ESC_LIMIT     = 3,
  parameter int GOOD_CYC      = 64,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timeout,
  input  logic             fault_clr,
  output logic             sys_rst,
  output logic             fault,
  output logic [CNT_W-1:0] to_count,
  output logic [1:0]       state_o
);

  localparam int ESC_W = $clog2(ESC_LIMIT + 1);
  localparam int QW    = $clog2(GOOD_CYC + 1);
  localparam int PMAX  = (RST_PULSE_CYC > HOLDOFF_CYC) ? RST_PULSE_CYC : HOLDOFF_CYC;
  localparam int PW    = $clog2(PMAX + 1);

  localparam logic [ESC_W-1:0] ESC_LAST   = ESC_W'(ESC_LIMIT - 1);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(GOOD_CYC - 1);
  localparam logic [PW-1:0]    PULSE_LOAD = PW'(RST_PULSE_CYC - 1);
  localparam logic [PW-1:0]    HOLD_LOAD  = PW'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           state;
  logic             timeout_p0;
  logic [ESC_W-1:0] esc_cnt;
  logic [QW-1:0]    quiet_cnt;
  logic [PW-1:0]    phase_cnt;
  logic             to_edge;

  // Saturating increment for the event counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // History is zero after reset, so a level that is already high on the first
  // cycle out of reset counts as an edge. A held level yields only one edge,
  // because the history tracks it in every state.
  assign to_edge = timeout & ~timeout_p0;

  assign state_o = state;

  // Stage p0: timeout history and the control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sys_rst    <= 1'b0;
      fault      <= 1'b0;
      to_count   <= '0;
      esc_cnt    <= '0;
      quiet_cnt  <= '0;
      phase_cnt  <= '0;
      timeout_p0 <= 1'b0;
    end else begin
      timeout_p0 <= timeout;
      // The quiet counter only runs in IDLE. Any other state leaves it at 0.
      quiet_cnt  <= '0;

      case (state)
        IDLE: begin
          if (to_edge) begin
            // The event wins over a simultaneous good-period clear.
            to_count <= sat_inc(to_count);
            esc_cnt  <= esc_cnt + ESC_W'(1);
            sys_rst  <= 1'b1;
            if (esc_cnt == ESC_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state     <= ASSERT;
              phase_cnt <= PULSE_LOAD;
            end
          end else if (quiet_cnt == QUIET_LAST) begin
            esc_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end

        ASSERT: begin
          if (phase_cnt == '0) begin
            state     <= HOLDOFF;
            sys_rst   <= 1'b0;
            phase_cnt <= HOLD_LOAD;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        HOLDOFF: begin
          if (phase_cnt == '0) begin
            state <= IDLE;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end

        FAULT: begin
          if (fault_clr) begin
            state     <= HOLDOFF;
            fault     <= 1'b0;
            sys_rst   <= 1'b0;
            esc_cnt   <= '0;
            phase_cnt <= HOLD_LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Directed bench for wdt_reset_ctrl with default parameters.
module tb_wdt_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timeout = 1'b0;
  logic       fault_clr = 1'b0;
  logic       sys_rst;
  logic       fault;
  logic [7:0] to_count;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  wdt_reset_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .timeout   (timeout),
    .fault_clr (fault_clr),
    .sys_rst   (sys_rst),
    .fault     (fault),
    .to_count  (to_count),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    timeout = 1'b0;
    fault_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // One-cycle timeout pulse; returns just after the edge that samples it.
  task automatic pulse();
    timeout = 1'b1;
    step();
    timeout = 1'b0;
  endtask

  initial begin
    int asserts;

    // Reset state
    do_reset();
    chk("rst_sys_rst", 32'(sys_rst), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_to_count", 32'(to_count), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);

    // Single pulse: 8 cycles ASSERT, then 16 cycles HOLDOFF, then IDLE
    step();
    pulse();
    chk("p1_state", 32'(state_o), 32'd1);
    chk("p1_sys_rst", 32'(sys_rst), 32'd1);
    chk("p1_to_count", 32'(to_count), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("p1_assert_sys_rst", 32'(sys_rst), 32'd1);
    end
    step();
    chk("p1_hold_state", 32'(state_o), 32'd2);
    chk("p1_hold_sys_rst", 32'(sys_rst), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk("p1_hold_state_n", 32'(state_o), 32'd2);
    end
    step();
    chk("p1_idle", 32'(state_o), 32'd0);
    chk("p1_count_end", 32'(to_count), 32'd1);

    // Level held high for 100 cycles, starting on the first cycle out of reset
    do_reset();
    timeout = 1'b1;
    asserts = 0;
    repeat (100) begin
      step();
      if (state_o == 2'd1) asserts++;
    end
    timeout = 1'b0;
    chk("lvl_assert_cycles", 32'(asserts), 32'd8);
    step();
    chk("lvl_to_count", 32'(to_count), 32'd1);
    chk("lvl_state", 32'(state_o), 32'd0);

    // Three pulses 40 cycles apart escalate to FAULT; fault_clr in IDLE is ignored
    do_reset();
    step();
    pulse();
    repeat (39) step();
    pulse();
    chk("esc2_state", 32'(state_o), 32'd1);
    repeat (29) step();
    chk("esc2_idle", 32'(state_o), 32'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    repeat (9) step();
    pulse();
    chk("esc3_state", 32'(state_o), 32'd3);
    chk("esc3_fault", 32'(fault), 32'd1);
    chk("esc3_sys_rst", 32'(sys_rst), 32'd1);
    chk("esc3_to_count", 32'(to_count), 32'd3);
    repeat (10) step();
    chk("fault_hold", 32'(fault), 32'd1);
    chk("fault_hold_sys_rst", 32'(sys_rst), 32'd1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_sys_rst", 32'(sys_rst), 32'd0);
    chk("clr_state", 32'(state_o), 32'd2);
    repeat (15) step();
    chk("clr_hold_last", 32'(state_o), 32'd2);
    step();
    chk("clr_idle", 32'(state_o), 32'd0);
    chk("clr_to_count", 32'(to_count), 32'd3);
    // The escalation count was cleared, so the next event is a normal one
    pulse();
    chk("post_clr_state", 32'(state_o), 32'd1);
    chk("post_clr_to_count", 32'(to_count), 32'd4);

    // Two events, a long quiet period, then one more event: no fault
    do_reset();
    step();
    pulse();
    repeat (39) step();
    pulse();
    repeat (24 + 70) step();
    chk("quiet_idle", 32'(state_o), 32'd0);
    pulse();
    chk("quiet_state", 32'(state_o), 32'd1);
    chk("quiet_fault", 32'(fault), 32'd0);
    chk("quiet_to_count", 32'(to_count), 32'd3);

    // Reset during the 4th ASSERT cycle
    do_reset();
    step();
    pulse();
    repeat (3) step();
    chk("mid_assert_state", 32'(state_o), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_sys_rst", 32'(sys_rst), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_to_count", 32'(to_count), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wdt_reset_ctrl.md
WDT_RESET_CTRL -- requirements
Module: wdt_reset_ctrl

Interface
REQ-001 The block SHALL provide the following parameters, one per line (name, default, meaning):
- RST_PULSE_CYC, 8, cycles sys_rst is held high per normal timeout event (>=1)
- HOLDOFF_CYC, 16, post-reset cycles during which timeout edges are ignored (>=1)
- ESC_LIMIT, 3, accepted events without an intervening good period that cause FAULT (>=1)
- GOOD_CYC, 64, consecutive IDLE cycles that clear the escalation count (>=1)
- CNT_W, 8, width of to_count
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic updates on its rising edge
- rst, in, 1, synchronous, active-high reset
- timeout, in, 1, watchdog expiry from the upstream watchdog_timer (level)
- fault_clr, in, 1, software clear of a latched fault
- sys_rst, out, 1, system/watchdog reset request
- fault, out, 1, latched escalation fault
- to_count, out, CNT_W, total accepted timeout events, saturating
- state_o, out, 2, FSM state: IDLE=0, ASSERT=1, HOLDOFF=2, FAULT=3

Function
REQ-003 The block SHALL register timeout every cycle in all states and SHALL define an edge as timeout=1 with the previous sampled value 0.
REQ-004 The block SHALL treat an edge as an accepted event only when state is IDLE; edges in ASSERT, HOLDOFF or FAULT SHALL be discarded.
REQ-005 A level held high SHALL produce exactly one edge; it SHALL NOT retrigger on entering IDLE.
REQ-006 On an accepted event in cycle N, the block SHALL increment esc_cnt (internal) and to_count, both visible at N+1.
REQ-007 If the incremented esc_cnt is below ESC_LIMIT, the block SHALL enter ASSERT at N+1 with sys_rst=1 for exactly RST_PULSE_CYC cycles (N+1 .. N+RST_PULSE_CYC).
REQ-008 After ASSERT, the block SHALL enter HOLDOFF with sys_rst=0 for exactly HOLDOFF_CYC cycles, then return to IDLE.
REQ-009 If the incremented esc_cnt equals ESC_LIMIT, the block SHALL enter FAULT at N+1 with sys_rst=1 and fault=1.
REQ-010 In FAULT, sys_rst and fault SHALL stay 1 until fault_clr=1 is sampled.
REQ-011 On fault_clr in FAULT, the next cycle SHALL have fault=0, sys_rst=0, esc_cnt=0 and state HOLDOFF; HOLDOFF then runs as in REQ-008.
REQ-012 The block SHALL ignore fault_clr in all states other than FAULT.
REQ-013 A quiet counter SHALL increment each cycle in IDLE with no accepted event, SHALL reset to 0 on an accepted event or on leaving IDLE, and SHALL clear esc_cnt and itself when it reaches GOOD_CYC.
REQ-014 If an accepted event and the quiet counter reaching GOOD_CYC occur in the same cycle, the event SHALL take precedence: esc_cnt = previous value + 1, with no clear.
REQ-015 to_count SHALL saturate at 2^CNT_W-1 and SHALL be cleared only by rst.
REQ-016 esc_cnt SHALL never exceed ESC_LIMIT.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While rst=1, the block SHALL set the following values at the next clock edge, in any state including mid-ASSERT and FAULT: state IDLE, sys_rst=0, fault=0, to_count=0, esc_cnt=0, quiet counter=0, timeout history register=0.
REQ-019 After reset, if timeout is high on the first cycle with rst=0, the block SHALL count it as an edge.

Verification (defaults)
REQ-020 The bench SHALL cover the following scenarios:
- rst high for 3 cycles -> sys_rst=0, fault=0, to_count=0, state_o=0.
- 1-cycle timeout pulse at cycle N -> sys_rst=1 on N+1..N+8; state_o=2 for N+9..N+24; state_o=0 at N+25; to_count=1.
- timeout held high 100 cycles from IDLE -> exactly one ASSERT, to_count=1.
- 3 pulses spaced 40 cycles -> 3rd gives fault=1, sys_rst=1 held; fault_clr pulse -> fault=0, 16 HOLDOFF cycles, then IDLE; to_count=3.
- 2 pulses, then 64+ quiet IDLE cycles, then 1 pulse -> normal ASSERT, fault stays 0.
- rst asserted during ASSERT cycle 4 -> next cycle sys_rst=0, state_o=0, to_count=0.
